// File: rtl/fmac_pkg.sv
// rtl/fmac_pkg.sv - FMAC shared types: decoded slot, EOF types, primitive bits, stats index
// Ports: none (package).
package fmac_pkg;

  // Ordered-set primitive flags carried with each decoded slot. IDLE is prim == 0.
  localparam int FC1_PRIM_W   = 4;
  localparam int FC1_PRIM_NOS = 0;
  localparam int FC1_PRIM_OLS = 1;
  localparam int FC1_PRIM_LR  = 2;
  localparam int FC1_PRIM_LRR = 3;

  typedef enum logic [2:0] {
    FC1_EOF_NORM_TYPE    = 3'd0,
    FC1_EOF_TERM_TYPE    = 3'd1,
    FC1_EOF_ABORT_TYPE   = 3'd2,
    FC1_EOF_NORM_I_TYPE  = 3'd3,
    FC1_EOF_A_TYPE       = 3'd4,
    FC1_EOF_INVALID_TYPE = 3'd7
  } fc1_eof_type_e;

  typedef struct packed {
    logic [FC1_PRIM_W-1:0] prim;
    logic                  code_viol;
    logic                  eof;
    fc1_eof_type_e         eof_type;
  } dec_intf;

  localparam int FC1_STATS_NUM = 8;

  typedef enum logic [2:0] {
    STAT_LINK_UP    = 3'd0,
    STAT_CODE_VIOL  = 3'd1,
    STAT_CRC_ERR    = 3'd2,
    STAT_LENGTH_ERR = 3'd3,
    STAT_NOS_OLS    = 3'd4,
    STAT_LR_LRR     = 3'd5,
    STAT_BAD_EOF    = 3'd6,
    STAT_LOSS_SYNC  = 3'd7
  } fmac_dec_stats_idx_e;

  // Any EOF that did not close the frame normally.
  function automatic logic is_bad_eof(input dec_intf s);
    return s.eof && (s.eof_type != FC1_EOF_NORM_TYPE);
  endfunction

endpackage

// File: rtl/fmac_stat_ctr.sv
// rtl/fmac_stat_ctr.sv - one live event counter with saturate/wrap add and a snapshot register
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   inc      : per-cycle increment (INC_W bits, zero-extended)
//   clr      : discard live count and snapshot (wins over tick)
//   tick     : move live+inc into snap and restart live at 0
//   snap     : stable snapshot value
module fmac_stat_ctr #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned INC_W    = 2,
  parameter int unsigned SAT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] snap
);

  logic [CNT_W-1:0] live;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] nxt;

  // One spare bit catches overflow so saturation needs no separate compare.
  always_comb begin
    sum = {1'b0, live} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
    if ((SAT_MODE != 0) && sum[CNT_W]) begin
      nxt = '1;
    end else begin
      nxt = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      live <= '0;
      snap <= '0;
    end else if (tick) begin
      // Tick-cycle events belong to the closing interval.
      snap <= nxt;
      live <= '0;
    end else begin
      live <= nxt;
    end
  end

endmodule

// File: rtl/fmac_dec_stats.sv
// rtl/fmac_dec_stats.sv - interval statistics engine for the FMAC receive path
// Ports:
//   clk, rst        : core clock, synchronous active-high reset
//   slot_i          : NUM_SLOTS decoded slots, index 0 earliest in stream order
//   slot_vld_i      : per-slot valid
//   crc_err_i       : one-cycle pulse per payload CRC error
//   length_err_i    : one-cycle pulse per frame length error
//   link_up_i       : link-up level (rising edges counted)
//   sync_lost_i     : loss-of-sync level (rising edges counted)
//   interval_tick_i : interval boundary pulse, snapshots live counters
//   clr_i           : clears live and snapshot banks, overrides tick
//   stats_o         : snapshot bank in fmac_dec_stats_idx_e order
//   snap_vld_o      : one-cycle pulse the cycle after stats_o updated
module fmac_dec_stats
  import fmac_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned SAT_MODE  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  dec_intf [NUM_SLOTS-1:0]             slot_i,
  input  logic [NUM_SLOTS-1:0]                slot_vld_i,
  input  logic                                crc_err_i,
  input  logic                                length_err_i,
  input  logic                                link_up_i,
  input  logic                                sync_lost_i,
  input  logic                                interval_tick_i,
  input  logic                                clr_i,
  output logic [FC1_STATS_NUM-1:0][CNT_W-1:0] stats_o,
  output logic                                snap_vld_o
);

  localparam int unsigned INC_W = $clog2(NUM_SLOTS + 1);

  logic             in_nos_ols;
  logic             in_lr_lrr;
  logic             link_up_q;
  logic             sync_lost_q;

  logic [INC_W-1:0] cv_cnt;
  logic [INC_W-1:0] eof_cnt;
  logic [INC_W-1:0] nos_cnt;
  logic [INC_W-1:0] lr_cnt;
  logic             nos_prev;
  logic             lr_prev;
  logic             nos_cur;
  logic             lr_cur;

  logic [INC_W-1:0] inc [FC1_STATS_NUM];

  // Walk the slots in stream order; nos_prev/lr_prev carry the state of the
  // previous valid slot, seeded from last cycle's flags so a run that spans
  // a cycle edge is still counted once. Invalid slots are skipped entirely.
  always_comb begin
    cv_cnt   = '0;
    eof_cnt  = '0;
    nos_cnt  = '0;
    lr_cnt   = '0;
    nos_prev = in_nos_ols;
    lr_prev  = in_lr_lrr;
    nos_cur  = 1'b0;
    lr_cur   = 1'b0;
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      if (slot_vld_i[s]) begin
        if (slot_i[s].code_viol) begin
          cv_cnt = cv_cnt + INC_W'(1);
        end
        if (is_bad_eof(slot_i[s])) begin
          eof_cnt = eof_cnt + INC_W'(1);
        end
        nos_cur = slot_i[s].prim[FC1_PRIM_NOS] | slot_i[s].prim[FC1_PRIM_OLS];
        lr_cur  = slot_i[s].prim[FC1_PRIM_LR]  | slot_i[s].prim[FC1_PRIM_LRR];
        if (nos_cur && !nos_prev) begin
          nos_cnt = nos_cnt + INC_W'(1);
        end
        if (lr_cur && !lr_prev) begin
          lr_cnt = lr_cnt + INC_W'(1);
        end
        nos_prev = nos_cur;
        lr_prev  = lr_cur;
      end
    end
  end

  always_comb begin
    inc[int'(STAT_LINK_UP)]    = INC_W'(link_up_i & ~link_up_q);
    inc[int'(STAT_CODE_VIOL)]  = cv_cnt;
    inc[int'(STAT_CRC_ERR)]    = INC_W'(crc_err_i);
    inc[int'(STAT_LENGTH_ERR)] = INC_W'(length_err_i);
    inc[int'(STAT_NOS_OLS)]    = nos_cnt;
    inc[int'(STAT_LR_LRR)]     = lr_cnt;
    inc[int'(STAT_BAD_EOF)]    = eof_cnt;
    inc[int'(STAT_LOSS_SYNC)]  = INC_W'(sync_lost_i & ~sync_lost_q);
  end

  // History and edge state survive clr_i; only rst clears them. With no
  // valid slot nos_prev/lr_prev equal the current flags, so they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_nos_ols  <= 1'b0;
      in_lr_lrr   <= 1'b0;
      link_up_q   <= 1'b0;
      sync_lost_q <= 1'b0;
      snap_vld_o  <= 1'b0;
    end else begin
      in_nos_ols  <= nos_prev;
      in_lr_lrr   <= lr_prev;
      link_up_q   <= link_up_i;
      sync_lost_q <= sync_lost_i;
      snap_vld_o  <= interval_tick_i & ~clr_i;
    end
  end

  for (genvar i = 0; i < FC1_STATS_NUM; i++) begin : g_ctr
    fmac_stat_ctr #(
      .CNT_W    (CNT_W),
      .INC_W    (INC_W),
      .SAT_MODE (SAT_MODE)
    ) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[i]),
      .clr  (clr_i),
      .tick (interval_tick_i),
      .snap (stats_o[i])
    );
  end

endmodule

// File: tb/tb_fmac_dec_stats.sv
// tb/tb_fmac_dec_stats.sv - scoreboard bench for fmac_dec_stats (32-bit sat, 16-bit sat, 16-bit wrap)
module tb_fmac_dec_stats;
  import fmac_pkg::*;

  localparam int NS = 2;
  localparam logic [3:0] P_IDLE = 4'b0000;
  localparam logic [3:0] P_NOS  = 4'b0001;
  localparam logic [3:0] P_OLS  = 4'b0010;
  localparam logic [3:0] P_LR   = 4'b0100;
  localparam logic [3:0] P_LRR  = 4'b1000;

  typedef logic [7:0][31:0] exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  dec_intf [NS-1:0]   slot;
  logic [NS-1:0]      vld;
  logic               crc, len, lup, slost, tick, clr;
  logic [7:0][31:0]   st_main;
  logic [7:0][15:0]   st_sat;
  logic [7:0][15:0]   st_wrap;
  logic               sv_main, sv_sat, sv_wrap;

  exp_t  q[$];
  int    n_vec;
  int    n_err;
  string nm[8] = '{"link_up", "code_viol", "crc_err", "length_err",
                   "nos_ols", "lr_lrr", "bad_eof", "loss_sync"};

  fmac_dec_stats #(.NUM_SLOTS(NS), .CNT_W(32), .SAT_MODE(1)) u_main (
    .clk(clk), .rst(rst), .slot_i(slot), .slot_vld_i(vld), .crc_err_i(crc),
    .length_err_i(len), .link_up_i(lup), .sync_lost_i(slost),
    .interval_tick_i(tick), .clr_i(clr), .stats_o(st_main), .snap_vld_o(sv_main));

  fmac_dec_stats #(.NUM_SLOTS(NS), .CNT_W(16), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .slot_i(slot), .slot_vld_i(vld), .crc_err_i(crc),
    .length_err_i(len), .link_up_i(lup), .sync_lost_i(slost),
    .interval_tick_i(tick), .clr_i(clr), .stats_o(st_sat), .snap_vld_o(sv_sat));

  fmac_dec_stats #(.NUM_SLOTS(NS), .CNT_W(16), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .slot_i(slot), .slot_vld_i(vld), .crc_err_i(crc),
    .length_err_i(len), .link_up_i(lup), .sync_lost_i(slost),
    .interval_tick_i(tick), .clr_i(clr), .stats_o(st_wrap), .snap_vld_o(sv_wrap));

  // Map a true event count onto what a counter of width w and mode sat holds.
  function automatic logic [31:0] fit(input logic [31:0] v, input int w, input bit sat);
    if (w >= 32) return v;
    if (v > 32'h0000_FFFF) return sat ? 32'h0000_FFFF : (v & 32'h0000_FFFF);
    return v;
  endfunction

  function automatic dec_intf mk(input logic [3:0] prim, input logic cv,
                                 input logic eof, input fc1_eof_type_e t);
    dec_intf d;
    d.prim      = prim;
    d.code_viol = cv;
    d.eof       = eof;
    d.eof_type  = t;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sv_main | sv_sat | sv_wrap) begin
        if (q.size() == 0) begin
          chk("unexpected_snap", 32'({sv_main, sv_sat, sv_wrap}), 32'd0);
        end else begin
          e = q.pop_front();
          chk("snap_vld_main", 32'(sv_main), 32'd1);
          chk("snap_vld_sat16", 32'(sv_sat), 32'd1);
          chk("snap_vld_wrap16", 32'(sv_wrap), 32'd1);
          for (int i = 0; i < 8; i++) begin
            chk($sformatf("main.%s", nm[i]), st_main[i], fit(e[i], 32, 1'b1));
            chk($sformatf("sat16.%s", nm[i]), {16'h0, st_sat[i]}, fit(e[i], 16, 1'b1));
            chk($sformatf("wrap16.%s", nm[i]), {16'h0, st_wrap[i]}, fit(e[i], 16, 1'b0));
          end
        end
      end
    end
  endtask

  task automatic idle_in();
    slot = '0;
    vld  = '0;
    crc  = 1'b0;
    len  = 1'b0;
    tick = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic set_slots(input dec_intf s0, input logic v0, input dec_intf s1, input logic v1);
    slot[0] = s0;
    vld[0]  = v0;
    slot[1] = s1;
    vld[1]  = v1;
  endtask

  task automatic do_tick(input exp_t e);
    q.push_back(e);
    tick = 1'b1;
    step();
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.main.%s", tag, nm[i]), st_main[i], 32'd0);
      chk($sformatf("%s.sat16.%s", tag, nm[i]), {16'h0, st_sat[i]}, 32'd0);
      chk($sformatf("%s.wrap16.%s", tag, nm[i]), {16'h0, st_wrap[i]}, 32'd0);
    end
    chk({tag, ".snap_vld"}, 32'({sv_main, sv_sat, sv_wrap}), 32'd0);
  endtask

  initial begin
    exp_t    e;
    dec_intf cv_s;
    cv_s  = mk(P_IDLE, 1'b1, 1'b0, FC1_EOF_NORM_TYPE);
    n_vec = 0;
    n_err = 0;
    idle_in();
    lup   = 1'b0;
    slost = 1'b0;
    rst   = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    step();
    check_zero("post_reset");

    // 10 cycles x 2 code violations
    for (int c = 0; c < 10; c++) begin
      set_slots(cv_s, 1'b1, cv_s, 1'b1);
      step();
    end
    e = '0; e[1] = 20;
    do_tick(e);
    step();

    // NOS/OLS runs across an idle cycle and a cycle edge, then one LR->LRR run
    set_slots(cv_s, 1'b0, mk(P_NOS, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1);
    step();
    step();
    set_slots(mk(P_NOS, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1,
              mk(P_IDLE, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1);
    step();
    set_slots(mk(P_OLS, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1,
              mk(P_OLS, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1);
    step();
    set_slots(mk(P_LR, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1,
              mk(P_LRR, 1'b0, 1'b0, FC1_EOF_NORM_TYPE), 1'b1);
    step();
    e = '0; e[4] = 2; e[5] = 1;
    do_tick(e);
    step();

    // EOF types: TERM, ABORT, NORM, NORM_I, INVALID valid; EOF_A on an invalid slot
    set_slots(mk(P_IDLE, 1'b0, 1'b1, FC1_EOF_TERM_TYPE), 1'b1,
              mk(P_IDLE, 1'b0, 1'b1, FC1_EOF_ABORT_TYPE), 1'b1);
    step();
    set_slots(mk(P_IDLE, 1'b0, 1'b1, FC1_EOF_NORM_TYPE), 1'b1,
              mk(P_IDLE, 1'b0, 1'b1, FC1_EOF_NORM_I_TYPE), 1'b1);
    step();
    set_slots(mk(P_IDLE, 1'b0, 1'b1, FC1_EOF_INVALID_TYPE), 1'b1,
              mk(P_IDLE, 1'b0, 1'b1, FC1_EOF_A_TYPE), 1'b0);
    step();
    e = '0; e[6] = 4;
    do_tick(e);
    step();

    // back-to-back ticks: one crc in the first, nothing in the second
    crc = 1'b1;
    e = '0; e[2] = 1;
    do_tick(e);
    e = '0;
    do_tick(e);
    step();

    // 3 events on a tick cycle, then 2 events, then an idle tick
    set_slots(cv_s, 1'b1, cv_s, 1'b1);
    crc = 1'b1;
    e = '0; e[1] = 2; e[2] = 1;
    do_tick(e);
    set_slots(cv_s, 1'b1, cv_s, 1'b0);
    len = 1'b1;
    step();
    e = '0; e[1] = 1; e[3] = 1;
    do_tick(e);
    step();

    // clr together with tick: no snapshot, banks zero, clr-cycle events lost
    crc = 1'b1;
    step();
    crc = 1'b1;
    step();
    crc  = 1'b1;
    clr  = 1'b1;
    tick = 1'b1;
    step();
    check_zero("clr_tick");
    len = 1'b1;
    step();
    e = '0; e[3] = 1;
    do_tick(e);
    step();

    // rst mid-interval with link_up already high, then a sync_lost edge
    crc = 1'b1;
    step();
    lup = 1'b1;
    rst = 1'b1;
    step();
    step();
    check_zero("rst_mid");
    rst = 1'b0;
    step();
    check_zero("post_rst");
    slost = 1'b1;
    step();
    step();
    slost = 1'b0;
    step();
    e = '0; e[0] = 1; e[7] = 1;
    do_tick(e);
    step();

    // 70000 crc pulses, the last on the tick cycle
    for (int c = 0; c < 69999; c++) begin
      crc = 1'b1;
      step();
    end
    crc = 1'b1;
    e = '0; e[2] = 70000;
    do_tick(e);

    for (int w = 0; w < 10 && q.size() != 0; w++) begin
      @(posedge clk);
    end
    @(posedge clk);
    chk("pending_snapshots", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fmac_dec_stats.md
Name: fmac_dec_stats

Overview:
- Parametrised interval statistics engine for the FMAC receive path.
- Consumes NUM_SLOTS decoded transmission-word slots per clock (dec_intf from fmac_pkg) plus frame-level CRC and length error pulses.
- Accumulates 8 live error/event counters and snapshots them into a stable bank on each interval tick.
- Generalises the fixed 32-bit, 1-slot-per-cycle stats in width, slot count and wrap/saturate mode, and adds transition detection that spans slot and cycle boundaries.

Parameters:
- NUM_SLOTS, 2, decoded slots presented per clock (1..8).
- CNT_W, 32, counter width (16..48).
- SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- slot_i  in  NUM_SLOTS x dec_intf  decoded slots; index 0 is earliest in stream order.
- slot_vld_i  in  NUM_SLOTS  per-slot valid.
- crc_err_i  in  1  one-cycle pulse, one payload CRC error.
- length_err_i  in  1  one-cycle pulse, one frame length error.
- link_up_i  in  1  link-up level.
- sync_lost_i  in  1  loss-of-sync level.
- interval_tick_i  in  1  interval boundary pulse.
- clr_i  in  1  software clear of live and snapshot banks.
- stats_o  out  8 x CNT_W  snapshot bank, fmac_dec_stats_t order.
- snap_vld_o  out  1  one-cycle pulse when stats_o has updated.

Behaviour:
- Reset: rst is synchronous and active-high. It clears all live counters, stats_o and snap_vld_o to 0, the transition history flags, and the link_up_i / sync_lost_i edge registers (both to 0).
- Counter index order is fixed: 0 link_up, 1 code_viol, 2 crc_err, 3 length_err, 4 nos_ols, 5 lr_lrr, 6 bad_eof, 7 loss_sync.
- Per-cycle increments. Only slots with slot_vld_i = 1 count.
  - code_viol: number of valid slots with code_viol = 1.
  - bad_eof: number of valid slots with eof = 1 and eof_type not equal to FC1_EOF_NORM_TYPE.
  - nos_ols: a valid slot counts if prim[NOS] or prim[OLS] is set and the previous valid slot in stream order did not have either bit set. "Previous" chains across slots within a cycle and across cycles through the flag in_nos_ols.
  - lr_lrr: same rule using prim[LR] / prim[LRR] and the flag in_lr_lrr.
  - History flags update from the last valid slot of the cycle. They hold when no slot is valid.
  - crc_err, length_err: +1 when the corresponding pulse is high.
  - link_up: +1 on a rising edge of link_up_i (registered compare).
  - loss_sync: +1 on a rising edge of sync_lost_i.
- Arithmetic: each increment is $clog2(NUM_SLOTS+1) bits wide and zero-extended to CNT_W+1 before the add.
  - SAT_MODE = 1: if the sum exceeds 2^CNT_W−1, the result is all-ones and stays there until cleared.
  - SAT_MODE = 0: the result is truncated to CNT_W bits.
- Interval tick:
  - On the cycle interval_tick_i = 1, stats_o takes the live value including that cycle's increment, and snap_vld_o is 1 on the next cycle.
  - Live counters restart at 0; events of the tick cycle are counted into the closing interval.
  - Latency from tick to valid snapshot is 1 clock.
- clr_i:
  - Zeroes live counters and stats_o on the next cycle.
  - Events in the clr cycle are discarded.
  - History and edge flags are not cleared.
  - clr_i has priority over interval_tick_i; snap_vld_o stays 0 in that case.
- Back-to-back ticks on consecutive cycles are legal. Each tick produces a snapshot of exactly one cycle of events.
- Idle cycles (all slot_vld_i = 0) hold the transition flags.
- rst asserted mid-interval discards all accumulated counts with no snapshot.

Decomposition:
- Add to fmac_pkg:
  - typedef fmac_dec_stats_idx_e, the 8-entry enum giving the index order above.
  - localparam FC1_STATS_NUM = 8.
  - No credit fields; credit statistics belong to a separate block.
- One sub-module, fmac_stat_ctr: a single CNT_W counter with increment input, SAT_MODE, clear/restart, and a snapshot register.
  - Instantiated 8 times.
  - Slot reduction and transition logic stay in the top level.

Test Plan:
- NUM_SLOTS=2: 10 cycles with both slots valid and code_viol=1, then a tick → snap_vld_o on the next cycle, code_viol=20, all other counters 0.
- Slots alternate NOS, NOS, IDLE, OLS, OLS, with a NOS→NOS boundary across a cycle edge → nos_ols=2 at tick.
- CNT_W=16, SAT_MODE=1: 70000 crc_err_i pulses → crc_err=16'hFFFF. With SAT_MODE=0 the same stimulus gives 70000 mod 65536 = 4464.
- EOFs of type TERM, ABORT, NORM, NORM_I, INVALID, plus an invalid slot carrying EOF_A → bad_eof=4.
- 3 events on the tick cycle, then 2 events on the next cycle, then a second tick → first snapshot includes the 3 tick-cycle events; second snapshot is 2.
- clr_i and interval_tick_i together, then rst mid-interval → stats_o=0, no snap_vld_o; after rst all outputs 0, and a link_up_i that was already high at reset counts 1.
